// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared config word type and clamping for the programmable clock divider
package clk_div_pkg;

   localparam int unsigned CNT_W = 28;
   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

   typedef struct packed {
      logic [CNT_W-1:0] div;
      logic [CNT_W-1:0] high;
   } cfg_t;

   // Divisor at least 2, high-time in [1, D-1] so every period has both a high and a low phase.
   function automatic cfg_t clamp_cfg(input logic [CNT_W-1:0] div, input logic [CNT_W-1:0] high);
      cfg_t cfg;
      cfg.div  = (div < MIN_DIV) ? MIN_DIV : div;
      cfg.high = (high == '0) ? CNT_W'(1) : high;
      if (cfg.high > cfg.div - CNT_W'(1)) begin
         cfg.high = cfg.div - CNT_W'(1);
      end
      return cfg;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel: period counter, active/pending config, registered outputs
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(100000000)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic resync_i,
   input  logic load_i,
   input  cfg_t cfg_i,
   output logic busy_o,
   output logic clk_o,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] high_q, high_d;
   cfg_t             pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             wrap;
   logic             park;
   logic             commit;

   always_comb begin
      cnt_d        = cnt_q;
      div_d        = div_q;
      high_d       = high_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      clk_d        = 1'b0;
      tick_d       = 1'b0;

      wrap   = (cnt_q == div_q - ONE);
      park   = !en_i || resync_i;
      commit = pend_valid_q && (park || wrap);

      if (commit) begin
         div_d        = pend_q.div;
         high_d       = pend_q.high;
         pend_valid_d = 1'b0;
      end

      // The load strobe only arrives when the slot is empty, so it never races a commit.
      if (load_i) begin
         pend_d       = cfg_i;
         pend_valid_d = 1'b1;
      end

      // Parking at the terminal count makes the next enabled edge start a fresh period.
      if (park) begin
         cnt_d = div_d - ONE;
      end else begin
         cnt_d  = wrap ? '0 : cnt_q + ONE;
         clk_d  = (cnt_d < high_d);
         tick_d = (cnt_d == '0);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= DEFAULT_DIV - ONE;
         div_q        <= DEFAULT_DIV;
         high_q       <= DEFAULT_DIV >> 1;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         clk_q        <= 1'b0;
         tick_q       <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         high_q       <= high_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         clk_q        <= clk_d;
         tick_q       <= tick_d;
      end
   end

   assign busy_o = pend_valid_q;
   assign clk_o  = clk_q;
   assign tick_o = tick_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// rtl/programmable_clock_divider.sv - multi-channel programmable clock divider with glitch-free config handshake
module programmable_clock_divider
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 28,
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned DEFAULT_DIV = 100000000,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock_in,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              resync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_high,
   output logic [NUM_CH-1:0] clock_out,
   output logic [NUM_CH-1:0] tick
);

   localparam int unsigned CFG_W = $bits(cfg_t) / 2;

   cfg_t              cfg_clamped;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] load;

   assign cfg_clamped = clamp_cfg(CFG_W'(cfg_div), CFG_W'(cfg_high));

   // An out-of-range channel index reads as ready and the request is dropped, so a master never stalls.
   always_comb begin
      cfg_ready = 1'b1;
      load      = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = !busy[i];
            load[i]   = cfg_valid && !busy[i];
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
      clk_div_channel #(
         .DEFAULT_DIV(CFG_W'(DEFAULT_DIV))
      ) u_ch (
         .clk_i   (clock_in),
         .rst_ni  (reset_n),
         .en_i    (ch_en[g]),
         .resync_i(resync),
         .load_i  (load[g]),
         .cfg_i   (cfg_clamped),
         .busy_o  (busy[g]),
         .clk_o   (clock_out[g]),
         .tick_o  (tick[g])
      );
   end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// tb/tb_programmable_clock_divider.sv - self-checking bench against a period-position reference model
module tb_programmable_clock_divider;

   logic        clock_in;
   logic        reset_n;
   logic [1:0]  ch_en;
   logic        resync;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [0:0]  cfg_ch;
   logic [27:0] cfg_div;
   logic [27:0] cfg_high;
   logic [1:0]  clock_out;
   logic [1:0]  tick;

   int checks   = 0;
   int failures = 0;

   programmable_clock_divider #(
      .CNT_W(28),
      .NUM_CH(2),
      .DEFAULT_DIV(10)
   ) dut (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .ch_en    (ch_en),
      .resync   (resync),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .clock_out(clock_out),
      .tick     (tick)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   // pos = cycle index inside the current period, -1 while parked (disabled or realigning)
   typedef struct {
      int pos;
      int d;
      int h;
      int pd;
      int ph;
      bit pv;
   } ch_m_t;

   ch_m_t m[2];

   function automatic ch_m_t ch_next(ch_m_t s, bit en, bit rs, bit acc, int dv, int hv);
      ch_m_t n;
      n = s;
      if (!en || rs || s.pos == -1 || s.pos + 1 >= s.d) begin
         if (s.pv) begin
            n.d  = s.pd;
            n.h  = s.ph;
            n.pv = 1'b0;
         end
         n.pos = (!en || rs) ? -1 : 0;
      end else begin
         n.pos = s.pos + 1;
      end
      if (acc) begin
         n.pv = 1'b1;
         n.pd = (dv < 2) ? 2 : dv;
         n.ph = (hv < 1) ? 1 : hv;
         if (n.ph > n.pd - 1) n.ph = n.pd - 1;
      end
      return n;
   endfunction

   always @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < 2; c++) m[c] <= '{pos: -1, d: 10, h: 5, pd: 0, ph: 0, pv: 1'b0};
      end else begin
         for (int c = 0; c < 2; c++)
            m[c] <= ch_next(m[c], ch_en[c], resync,
                            cfg_valid && !m[cfg_ch].pv && (int'(cfg_ch) == c),
                            int'(cfg_div), int'(cfg_high));
      end
   end

   function automatic logic [4:0] exp_vec();
      logic [1:0] ec, et;
      for (int c = 0; c < 2; c++) begin
         ec[c] = (m[c].pos >= 0) && (m[c].pos < m[c].h);
         et[c] = (m[c].pos == 0);
      end
      return {ec, et, !m[cfg_ch].pv};
   endfunction

   task automatic load_cfg(input int ch, input int dv, input int hv);
      cfg_ch    = 1'(ch);
      cfg_div   = 28'(dv);
      cfg_high  = 28'(hv);
      cfg_valid = 1'b1;
      #1;
      for (int i = 0; i < 64 && !cfg_ready; i++) begin
         @(negedge clock_in);
         #1;
      end
      checks++;
      if (!cfg_ready) begin
         failures++;
         $display("FAIL load_cfg_timeout ch=%0d cfg_ready=%b required=1", ch, cfg_ready);
      end
      @(negedge clock_in);
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      int hi, tk;
      reset_n = 1'b0; ch_en = 2'b00; resync = 1'b0; cfg_valid = 1'b0;
      cfg_ch = '0; cfg_div = '0; cfg_high = '0;
      repeat (3) @(negedge clock_in);
      checks++;
      if ({clock_out, tick, cfg_ready} !== 5'b00001) begin
         failures++;
         $display("FAIL reset_state got=%b required=00001", {clock_out, tick, cfg_ready});
      end
      reset_n = 1'b1; ch_en = 2'b11;
      hi = 0; tk = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock_in);
         checks++;
         if ({clock_out, tick, cfg_ready} !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model t=%0t got=%b required=%b", $time, {clock_out, tick, cfg_ready}, exp_vec());
         end
         if (i == 0) begin
            checks++;
            if ({clock_out, tick} !== 4'b1111) begin
               failures++;
               $display("FAIL first_tick got=%b required=1111", {clock_out, tick});
            end
         end
         hi += int'(clock_out[0]);
         tk += int'(tick[0]);
      end
      checks++;
      if (hi != 10 || tk != 2) begin
         failures++;
         $display("FAIL default_shape high=%0d ticks=%0d required high=10 ticks=2", hi, tk);
      end
   endtask

   task automatic test_config_boundary();
      int hi, tk;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m[0].pos == 3) found = 1'b1;
         else @(negedge clock_in);
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL wait_pos3 pos=%0d required=3", m[0].pos);
      end
      load_cfg(0, 4, 1);
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_after_accept got=%b required=0", cfg_ready);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clock_in);
         checks++;
         if ({clock_out, tick, cfg_ready} !== exp_vec() || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL old_period t=%0t got=%b required=%b ready_req=0", $time, {clock_out, tick, cfg_ready}, exp_vec());
         end
      end
      hi = 0; tk = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock_in);
         checks++;
         if ({clock_out, tick, cfg_ready} !== exp_vec()) begin
            failures++;
            $display("FAIL new_period t=%0t got=%b required=%b", $time, {clock_out, tick, cfg_ready}, exp_vec());
         end
         if (i == 0) begin
            checks++;
            if (tick[0] !== 1'b1 || cfg_ready !== 1'b1) begin
               failures++;
               $display("FAIL wrap_commit tick0=%b ready=%b required 1 1", tick[0], cfg_ready);
            end
         end
         if (i < 4) hi += int'(clock_out[0]);
         tk += int'(tick[0]);
      end
      checks++;
      if (hi != 1 || tk != 2) begin
         failures++;
         $display("FAIL d4h1_shape high=%0d ticks=%0d required high=1 ticks=2", hi, tk);
      end
   endtask

   task automatic test_clamp();
      int dv[2] = '{0, 6};
      int hv[2] = '{0, 9};
      int win[2] = '{10, 12};
      int ehi[2] = '{5, 10};
      int etk[2] = '{5, 2};
      int hi, tk;
      bit found;
      for (int k = 0; k < 2; k++) begin
         load_cfg(0, dv[k], hv[k]);
         found = 1'b0;
         for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clock_in);
            checks++;
            if ({clock_out, tick, cfg_ready} !== exp_vec()) begin
               failures++;
               $display("FAIL clamp_model t=%0t got=%b required=%b", $time, {clock_out, tick, cfg_ready}, exp_vec());
            end
            if (tick[0] && !m[0].pv) found = 1'b1;
         end
         checks++;
         if (!found) begin
            failures++;
            $display("FAIL clamp_commit_timeout case=%0d tick0=%b required=1", k, tick[0]);
         end
         hi = 0; tk = 0;
         for (int i = 0; i < win[k]; i++) begin
            if (i > 0) @(negedge clock_in);
            hi += int'(clock_out[0]);
            tk += int'(tick[0]);
         end
         checks++;
         if (hi != ehi[k] || tk != etk[k]) begin
            failures++;
            $display("FAIL clamp_shape case=%0d high=%0d ticks=%0d required high=%0d ticks=%0d", k, hi, tk, ehi[k], etk[k]);
         end
      end
   endtask

   task automatic test_resync();
      int both;
      bit done;
      load_cfg(0, 4, 2);
      load_cfg(1, 6, 3);
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clock_in);
         if (!m[0].pv && !m[1].pv) done = 1'b1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL resync_setup_timeout pv=%b%b required=00", m[1].pv, m[0].pv);
      end
      ch_en = 2'b01;
      @(negedge clock_in);
      ch_en = 2'b11;
      repeat (3) @(negedge clock_in);
      resync = 1'b1;
      @(negedge clock_in);
      resync = 1'b0;
      checks++;
      if ({clock_out, tick} !== 4'b0000) begin
         failures++;
         $display("FAIL resync_park got=%b required=0000", {clock_out, tick});
      end
      @(negedge clock_in);
      checks++;
      if ({clock_out, tick} !== 4'b1111) begin
         failures++;
         $display("FAIL resync_align got=%b required=1111", {clock_out, tick});
      end
      both = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock_in);
         checks++;
         if ({clock_out, tick, cfg_ready} !== exp_vec()) begin
            failures++;
            $display("FAIL resync_model t=%0t got=%b required=%b", $time, {clock_out, tick, cfg_ready}, exp_vec());
         end
         if (tick == 2'b11) both++;
      end
      checks++;
      if (both != 1 || tick !== 2'b11) begin
         failures++;
         $display("FAIL resync_coincide count=%0d last_tick=%b required count=1 last=11", both, tick);
      end
   endtask

   task automatic test_enable();
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m[1].pos == 2) found = 1'b1;
         else @(negedge clock_in);
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL wait_ch1_pos2 pos=%0d required=2", m[1].pos);
      end
      ch_en = 2'b01;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock_in);
         checks++;
         if ({clock_out, tick, cfg_ready} !== exp_vec() || clock_out[1] !== 1'b0 || tick[1] !== 1'b0) begin
            failures++;
            $display("FAIL disabled t=%0t got=%b required=%b ch1_out_req=0", $time, {clock_out, tick, cfg_ready}, exp_vec());
         end
      end
      ch_en = 2'b11;
      @(negedge clock_in);
      checks++;
      if ({clock_out, tick, cfg_ready} !== exp_vec() || clock_out[1] !== 1'b1 || tick[1] !== 1'b1) begin
         failures++;
         $display("FAIL reenable got=%b required=%b ch1_out_tick_req=11", {clock_out, tick, cfg_ready}, exp_vec());
      end
   endtask

   task automatic test_reset_pending();
      int hi, tk;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (m[1].pos == 0) found = 1'b1;
         else @(negedge clock_in);
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL wait_ch1_pos0 pos=%0d required=0", m[1].pos);
      end
      load_cfg(1, 3, 2);
      checks++;
      if (cfg_ready !== 1'b0) begin
         failures++;
         $display("FAIL pending_before_reset ready=%b required=0", cfg_ready);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({clock_out, tick, cfg_ready} !== 5'b00001) begin
         failures++;
         $display("FAIL async_reset got=%b required=00001", {clock_out, tick, cfg_ready});
      end
      repeat (2) @(negedge clock_in);
      reset_n = 1'b1;
      hi = 0; tk = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clock_in);
         checks++;
         if ({clock_out, tick, cfg_ready} !== exp_vec()) begin
            failures++;
            $display("FAIL post_reset_model t=%0t got=%b required=%b", $time, {clock_out, tick, cfg_ready}, exp_vec());
         end
         if (i < 10) hi += int'(clock_out[1]);
         tk += int'(tick[1]);
      end
      checks++;
      if (hi != 5 || tk != 3) begin
         failures++;
         $display("FAIL pending_discarded high=%0d ticks=%0d required high=5 ticks=3", hi, tk);
      end
   endtask

   task automatic test_random();
      bit acc_next;
      int k;
      acc_next = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clock_in);
         checks++;
         if ({clock_out, tick, cfg_ready} !== exp_vec()) begin
            failures++;
            $display("FAIL random_model t=%0t got=%b required=%b", $time, {clock_out, tick, cfg_ready}, exp_vec());
         end
         if (acc_next) cfg_valid = 1'b0;
         if (!cfg_valid && $urandom_range(0, 3) == 0) begin
            cfg_ch    = 1'($urandom_range(0, 1));
            cfg_div   = 28'($urandom_range(0, 12));
            cfg_high  = 28'($urandom_range(0, 14));
            cfg_valid = 1'b1;
         end
         resync = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 29) == 0) begin
            k = int'($urandom_range(0, 1));
            ch_en[k] = ~ch_en[k];
         end
         #1;
         acc_next = cfg_valid && cfg_ready;
      end
      cfg_valid = 1'b0;
      resync    = 1'b0;
      ch_en     = 2'b11;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_config_boundary();
      test_clamp();
      test_resync();
      test_enable();
      test_reset_pending();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
